// File: rtl/nanomac_sdc_pkg.sv
// Shared constants and FSM state type for the SD drive arbiter.
package nanomac_sdc_pkg;

   localparam int NDRV      = 4;
   localparam int DRV_IDX_W = 2;
   localparam int LBA_W     = 24;
   localparam int SECTOR_W  = 32;

   typedef enum logic [2:0] {
      IDLE,
      START,
      XFER,
      DONE,
      ABORT
   } state_t;

endpackage

// File: rtl/rr_arbiter4.sv
// Four-way round-robin picker: the first requester at or after ptr wins.
module rr_arbiter4
   import nanomac_sdc_pkg::*;
(
   input  logic [NDRV-1:0]      req,
   input  logic [DRV_IDX_W-1:0] ptr,
   output logic [DRV_IDX_W-1:0] gnt_idx,
   output logic                 gnt_valid
);

   logic [DRV_IDX_W-1:0] w_idx;

   // Scan offsets from farthest to nearest so the nearest requester to ptr is the last write.
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = ptr;
      w_idx     = ptr;
      for (int k = NDRV - 1; k >= 0; k--) begin
         w_idx = ptr + DRV_IDX_W'(k);
         if (req[w_idx]) begin
            gnt_valid = 1'b1;
            gnt_idx   = w_idx;
         end
      end
   end

endmodule

// File: rtl/sdc_drive_arbiter.sv
// Shares one sd_rw sector engine among four virtual drives: round-robin grant,
// per-drive base sector offset, and a start/busy/done transfer sequence.
module sdc_drive_arbiter
   import nanomac_sdc_pkg::*;
#(
   parameter int START_TIMEOUT = 1023
)
(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NDRV-1:0]          drv_rd,
   input  logic [NDRV-1:0]          drv_wr,
   input  logic [NDRV*LBA_W-1:0]    drv_lba,
   input  logic [NDRV*SECTOR_W-1:0] drv_base,
   input  logic [NDRV*8-1:0]        drv_wdata,
   output logic [NDRV-1:0]          drv_busy,
   output logic [NDRV-1:0]          drv_done,
   output logic [NDRV-1:0]          drv_err,
   output logic [NDRV-1:0]          drv_data_en,
   output logic                     sd_rstart,
   output logic                     sd_wstart,
   output logic [SECTOR_W-1:0]      sd_sector,
   input  logic                     sd_busy,
   input  logic                     sd_done,
   input  logic                     sd_outen,
   output logic [7:0]               sd_inbyte
);

   localparam int CNT_W = $clog2(START_TIMEOUT + 1);

   state_t               r_state;
   state_t               w_nextState;
   logic [DRV_IDX_W-1:0] r_grant;
   logic [DRV_IDX_W-1:0] r_ptr;
   logic [DRV_IDX_W-1:0] w_gntIdx;
   logic                 w_gntValid;
   logic                 w_grantNow;
   logic                 w_timeout;
   logic                 r_isWrite;
   logic [NDRV-1:0]      r_armed;
   logic [NDRV-1:0]      w_reqAny;
   logic [NDRV-1:0]      w_elig;
   logic [SECTOR_W-1:0]  r_sector;
   logic [SECTOR_W-1:0]  w_newSector;
   logic [CNT_W-1:0]     r_count;

   assign w_reqAny   = drv_rd | drv_wr;
   assign w_elig     = w_reqAny & r_armed;
   assign w_grantNow = (r_state == IDLE) && w_gntValid;
   assign w_timeout  = (r_count == CNT_W'(START_TIMEOUT - 1));
   assign w_newSector = drv_base[SECTOR_W*w_gntIdx +: SECTOR_W]
                      + {{(SECTOR_W-LBA_W){1'b0}}, drv_lba[LBA_W*w_gntIdx +: LBA_W]};
   assign sd_sector  = r_sector;

   rr_arbiter4 u_arb (
      .req       (w_elig),
      .ptr       (r_ptr),
      .gnt_idx   (w_gntIdx),
      .gnt_valid (w_gntValid)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (reset) r_state <= IDLE;
      else       r_state <= w_nextState;
   end

   // Next-state logic; sd_busy wins over the timeout, and busy+done together skips XFER.
   always_comb begin
      w_nextState = r_state;
      case (r_state)
         IDLE:    if (w_gntValid) w_nextState = START;
         START: begin
            if (sd_busy && sd_done) w_nextState = DONE;
            else if (sd_busy)       w_nextState = XFER;
            else if (w_timeout)     w_nextState = ABORT;
         end
         XFER:    if (sd_done) w_nextState = DONE;
         DONE:    w_nextState = IDLE;
         ABORT:   w_nextState = IDLE;
         default: w_nextState = IDLE;
      endcase
   end

   // Grant latch, start-cycle counter, round-robin pointer and re-arm flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_grant   <= '0;
         r_ptr     <= '0;
         r_isWrite <= 1'b0;
         r_sector  <= '0;
         r_count   <= '0;
         r_armed   <= '1;
      end else begin
         if (w_grantNow) begin
            r_grant   <= w_gntIdx;
            r_isWrite <= drv_wr[w_gntIdx];
            r_sector  <= w_newSector;
            r_count   <= '0;
         end else if (r_state == START) begin
            r_count <= r_count + 1'b1;
         end
         if (r_state == DONE || r_state == ABORT) r_ptr <= r_grant + 1'b1;
         for (int i = 0; i < NDRV; i++) begin
            if (w_grantNow && (w_gntIdx == DRV_IDX_W'(i))) r_armed[i] <= 1'b0;
            else if (!w_reqAny[i])                          r_armed[i] <= 1'b1;
         end
      end
   end

   // Output decode from the registered state and grant; everything idles at zero.
   always_comb begin
      drv_busy    = '0;
      drv_done    = '0;
      drv_err     = '0;
      drv_data_en = '0;
      sd_rstart   = 1'b0;
      sd_wstart   = 1'b0;
      sd_inbyte   = 8'h00;
      case (r_state)
         START: begin
            sd_rstart         = !r_isWrite;
            sd_wstart         = r_isWrite;
            drv_busy[r_grant] = 1'b1;
         end
         XFER: begin
            drv_busy[r_grant]    = 1'b1;
            drv_data_en[r_grant] = sd_outen;
            sd_inbyte            = drv_wdata[8*r_grant +: 8];
         end
         DONE:    drv_done[r_grant] = 1'b1;
         ABORT:   drv_err[r_grant]  = 1'b1;
         default: ;
      endcase
   end

endmodule
